// File: rtl/pipe_link_pkg.sv
// PIPE link controller shared definitions.
// Link training states and the 32-bit training/idle symbols.
package pipe_link_pkg;

  typedef enum logic [2:0] {
    DETECT   = 3'd0,
    POLL     = 3'd1,
    CONFIG   = 3'd2,
    IDLE_ST  = 3'd3,
    L0       = 3'd4,
    RECOVERY = 3'd5
  } link_state_e;

  localparam logic [31:0] TS1_SYM  = 32'h1E1E_4A4A;
  localparam logic [31:0] TS2_SYM  = 32'h2D2D_4545;
  localparam logic [31:0] IDLE_SYM = 32'h7C7C_0000;

  localparam int DETECT_CYCLES = 16;

endpackage

// File: rtl/pipe_sym_detect.sv
// Received-word symbol classifier.
// Flags a PIPE word that is a full replication of TS1, TS2 or IDLE.
module pipe_sym_detect
  import pipe_link_pkg::*;
#(
  parameter int PIPE_DATA_WIDTH = 256
) (
  input  logic [PIPE_DATA_WIDTH-1:0] data_i,
  output logic                       ts1_o,
  output logic                       ts2_o,
  output logic                       idle_o
);

  localparam int NSYM = PIPE_DATA_WIDTH / 32;

  localparam logic [PIPE_DATA_WIDTH-1:0] TS1_W  = {NSYM{TS1_SYM}};
  localparam logic [PIPE_DATA_WIDTH-1:0] TS2_W  = {NSYM{TS2_SYM}};
  localparam logic [PIPE_DATA_WIDTH-1:0] IDLE_W = {NSYM{IDLE_SYM}};

  assign ts1_o  = (data_i == TS1_W);
  assign ts2_o  = (data_i == TS2_W);
  assign idle_o = (data_i == IDLE_W);

endmodule

// File: rtl/pipe_link_ctrl.sv
// PIPE link training controller.
// Trains the link through DETECT/POLL/CONFIG/IDLE, then bridges DLL<->PHY in L0.
module pipe_link_ctrl
  import pipe_link_pkg::*;
#(
  parameter int PIPE_DATA_WIDTH = 256,
  parameter int TS_RX_CNT       = 8,
  parameter int TS_TX_MIN       = 16,
  parameter int IDLE_CNT        = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PIPE_DATA_WIDTH-1:0] dll_txdata_i,
  input  logic                       dll_txvalid_i,
  output logic [PIPE_DATA_WIDTH-1:0] dll_rxdata_o,
  output logic                       dll_rxvalid_o,
  output logic [PIPE_DATA_WIDTH-1:0] phy_txdata_o,
  output logic                       phy_txvalid_o,
  input  logic [PIPE_DATA_WIDTH-1:0] phy_rxdata_i,
  input  logic                       phy_rxvalid_i,
  input  logic                       retrain_i,
  output logic                       link_up_o,
  output logic [2:0]                 link_state_o
);

  localparam int W    = PIPE_DATA_WIDTH;
  localparam int NSYM = W / 32;

  localparam int RUN_MAX = (TS_RX_CNT > IDLE_CNT) ? TS_RX_CNT : IDLE_CNT;
  localparam int TO_MAX  = (TIMEOUT_CYCLES > DETECT_CYCLES)
                         ? TIMEOUT_CYCLES : DETECT_CYCLES;
  localparam int RW = $clog2(RUN_MAX + 1);
  localparam int TW = $clog2(TS_TX_MIN + 1);
  localparam int OW = $clog2(TO_MAX + 1);

  localparam logic [RW-1:0] RUN_SAT = RW'(RUN_MAX);
  localparam logic [RW-1:0] RX_TGT  = RW'(TS_RX_CNT);
  localparam logic [RW-1:0] IDL_TGT = RW'(IDLE_CNT);
  localparam logic [TW-1:0] TX_TGT  = TW'(TS_TX_MIN);
  localparam logic [OW-1:0] TO_SAT  = OW'(TO_MAX);
  localparam logic [OW-1:0] TO_TGT  = OW'(TIMEOUT_CYCLES);
  localparam logic [OW-1:0] DET_TGT = OW'(DETECT_CYCLES);

  localparam logic [W-1:0] TS1_W  = {NSYM{TS1_SYM}};
  localparam logic [W-1:0] TS2_W  = {NSYM{TS2_SYM}};
  localparam logic [W-1:0] IDLE_W = {NSYM{IDLE_SYM}};

  link_state_e   state_q, state_d;
  logic [RW-1:0] run_q, run_d, run_nxt;
  logic [TW-1:0] tx_q, tx_d, tx_nxt;
  logic [OW-1:0] to_q, to_d, to_nxt;
  logic          run_match, timeout, entry;

  logic          rx_ts1, rx_ts2, rx_idle;

  logic [W-1:0]  ptxd_q, ptxd_d;
  logic          ptxv_q, ptxv_d;
  logic [W-1:0]  drxd_q, drxd_d;
  logic          drxv_q, drxv_d;
  logic          up_q;

  pipe_sym_detect #(
    .PIPE_DATA_WIDTH (W)
  ) u_sym (
    .data_i (phy_rxdata_i),
    .ts1_o  (rx_ts1),
    .ts2_o  (rx_ts2),
    .idle_o (rx_idle)
  );

  // Run/tx/timeout counter increments; the run only counts words valid in this state.
  always_comb begin
    run_match = 1'b0;
    unique case (state_q)
      POLL, RECOVERY: run_match = rx_ts1 | rx_ts2;
      CONFIG:         run_match = rx_ts2;
      IDLE_ST:        run_match = rx_idle;
      default:        run_match = 1'b0;
    endcase
    if (phy_rxvalid_i && run_match)
      run_nxt = (run_q == RUN_SAT) ? run_q : run_q + RW'(1);
    else
      run_nxt = '0;
    tx_nxt  = (tx_q == TX_TGT) ? tx_q : tx_q + TW'(1);
    to_nxt  = (to_q == TO_SAT) ? to_q : to_q + OW'(1);
    timeout = (to_nxt >= TO_TGT);
  end

  // Next-state logic; timeout beats any advance in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DETECT:
        if (to_nxt >= DET_TGT) state_d = POLL;
      POLL:
        if (timeout) state_d = DETECT;
        else if (run_nxt >= RX_TGT && tx_nxt >= TX_TGT) state_d = CONFIG;
      CONFIG:
        if (timeout) state_d = DETECT;
        else if (run_nxt >= RX_TGT && tx_nxt >= TX_TGT) state_d = IDLE_ST;
      IDLE_ST:
        if (timeout) state_d = DETECT;
        else if (run_nxt >= IDL_TGT) state_d = L0;
      L0:
        if (retrain_i || (phy_rxvalid_i && rx_ts1)) state_d = RECOVERY;
      RECOVERY:
        if (timeout) state_d = DETECT;
        else if (run_nxt >= RX_TGT) state_d = CONFIG;
      default:
        state_d = DETECT;
    endcase
    entry = (state_d != state_q);
    run_d = entry ? '0 : run_nxt;
    tx_d  = entry ? '0 : tx_nxt;
    to_d  = entry ? '0 : to_nxt;
  end

  // Registered PHY/DLL word selection for the current state.
  always_comb begin
    ptxv_d = 1'b0;
    ptxd_d = '0;
    drxv_d = 1'b0;
    drxd_d = '0;
    unique case (state_q)
      POLL, RECOVERY: begin
        ptxv_d = 1'b1;
        ptxd_d = TS1_W;
      end
      CONFIG: begin
        ptxv_d = 1'b1;
        ptxd_d = TS2_W;
      end
      IDLE_ST: begin
        ptxv_d = 1'b1;
        ptxd_d = IDLE_W;
      end
      L0: begin
        ptxv_d = dll_txvalid_i & ~retrain_i;
        ptxd_d = ptxv_d ? dll_txdata_i : '0;
        drxv_d = phy_rxvalid_i & ~rx_ts1;
        drxd_d = drxv_d ? phy_rxdata_i : '0;
      end
      default: ;
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DETECT;
      run_q   <= '0;
      tx_q    <= '0;
      to_q    <= '0;
      ptxv_q  <= 1'b0;
      ptxd_q  <= '0;
      drxv_q  <= 1'b0;
      drxd_q  <= '0;
      up_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      tx_q    <= tx_d;
      to_q    <= to_d;
      ptxv_q  <= ptxv_d;
      ptxd_q  <= ptxd_d;
      drxv_q  <= drxv_d;
      drxd_q  <= drxd_d;
      up_q    <= (state_d == L0);
    end
  end

  assign phy_txvalid_o = ptxv_q;
  assign phy_txdata_o  = ptxd_q;
  assign dll_rxvalid_o = drxv_q;
  assign dll_rxdata_o  = drxd_q;
  assign link_up_o     = up_q;
  assign link_state_o  = state_q;

endmodule

// File: tb/tb_pipe_link_ctrl.sv
// Bench for pipe_link_ctrl.
// Directed training scenarios plus randomized partner traffic vs a reference model.
module tb_pipe_link_ctrl;

  localparam int W     = 256;
  localparam int RX    = 8;
  localparam int TXMIN = 16;
  localparam int IDL   = 4;
  localparam int TO    = 1024;

  localparam logic [W-1:0] TS1W  = {8{32'h1E1E_4A4A}};
  localparam logic [W-1:0] TS2W  = {8{32'h2D2D_4545}};
  localparam logic [W-1:0] IDLEW = {8{32'h7C7C_0000}};
  localparam logic [W-1:0] A5W   = {32{8'hA5}};
  localparam logic [W-1:0] X5AW  = {32{8'h5A}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] dll_txdata_i = '0;
  logic         dll_txvalid_i = 1'b0;
  logic [W-1:0] dll_rxdata_o;
  logic         dll_rxvalid_o;
  logic [W-1:0] phy_txdata_o;
  logic         phy_txvalid_o;
  logic [W-1:0] phy_rxdata_i = '0;
  logic         phy_rxvalid_i = 1'b0;
  logic         retrain_i = 1'b0;
  logic         link_up_o;
  logic [2:0]   link_state_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_link_ctrl #(
    .PIPE_DATA_WIDTH (W),
    .TS_RX_CNT       (RX),
    .TS_TX_MIN       (TXMIN),
    .IDLE_CNT        (IDL),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dll_txdata_i  (dll_txdata_i),
    .dll_txvalid_i (dll_txvalid_i),
    .dll_rxdata_o  (dll_rxdata_o),
    .dll_rxvalid_o (dll_rxvalid_o),
    .phy_txdata_o  (phy_txdata_o),
    .phy_txvalid_o (phy_txvalid_o),
    .phy_rxdata_i  (phy_rxdata_i),
    .phy_rxvalid_i (phy_rxvalid_i),
    .retrain_i     (retrain_i),
    .link_up_o     (link_up_o),
    .link_state_o  (link_state_o)
  );

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: state number, run length, words sent, cycles in state
  int           m_st, m_run, m_tx, m_tm;
  logic         e_tv, e_rv;
  logic [W-1:0] e_td, e_rd;
  bit           chk_en = 0;

  task automatic model(input logic r, input logic dv, input logic [W-1:0] dd,
                       input logic pv, input logic [W-1:0] pd, input logic rt);
    int nst, run_n;
    bit match, tmo;
    e_tv = 0; e_td = '0; e_rv = 0; e_rd = '0;
    if (r) begin
      m_st = 0; m_run = 0; m_tx = 0; m_tm = 0;
      return;
    end
    case (m_st)
      1, 5: begin e_tv = 1; e_td = TS1W; end
      2:    begin e_tv = 1; e_td = TS2W; end
      3:    begin e_tv = 1; e_td = IDLEW; end
      4: begin
        e_tv = dv && !rt;
        if (e_tv) e_td = dd;
        e_rv = pv && (pd != TS1W);
        if (e_rv) e_rd = pd;
      end
      default: ;
    endcase
    case (m_st)
      1, 5:    match = (pd == TS1W) || (pd == TS2W);
      2:       match = (pd == TS2W);
      3:       match = (pd == IDLEW);
      default: match = 0;
    endcase
    run_n = (pv && match) ? m_run + 1 : 0;
    tmo   = (m_tm + 1 >= TO);
    nst   = m_st;
    case (m_st)
      0: if (m_tm + 1 >= 16) nst = 1;
      1: if (tmo) nst = 0;
         else if (run_n >= RX && m_tx + 1 >= TXMIN) nst = 2;
      2: if (tmo) nst = 0;
         else if (run_n >= RX && m_tx + 1 >= TXMIN) nst = 3;
      3: if (tmo) nst = 0;
         else if (run_n >= IDL) nst = 4;
      4: if (rt || (pv && pd == TS1W)) nst = 5;
      5: if (tmo) nst = 0;
         else if (run_n >= RX) nst = 2;
      default: nst = 0;
    endcase
    if (nst != m_st) begin
      m_st = nst; m_run = 0; m_tx = 0; m_tm = 0;
    end else begin
      m_run = run_n; m_tx++; m_tm++;
    end
  endtask

  // check the previous edge's outputs, drive new inputs, advance the model
  task automatic step(input logic r, input logic dv, input logic [W-1:0] dd,
                      input logic pv, input logic [W-1:0] pd, input logic rt);
    @(negedge clk);
    if (chk_en) begin
      chk("state", W'(link_state_o), W'(m_st));
      chk("link_up", W'(link_up_o), W'(m_st == 4));
      chk("ptx_valid", W'(phy_txvalid_o), W'(e_tv));
      chk("ptx_data", phy_txdata_o, e_td);
      chk("drx_valid", W'(dll_rxvalid_o), W'(e_rv));
      chk("drx_data", dll_rxdata_o, e_rd);
    end
    rst = r; dll_txvalid_i = dv; dll_txdata_i = dd;
    phy_rxvalid_i = pv; phy_rxdata_i = pd; retrain_i = rt;
    model(r, dv, dd, pv, pd, rt);
    chk_en = 1;
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] w;
    for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic silent(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0, 0);
  endtask

  task automatic rx_word(input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 1, w, 0);
  endtask

  // a cooperative link partner with optional errors, retrains and resets
  task automatic pstep(input int err, input int rt_pct);
    logic         pv, rt, r;
    logic [W-1:0] pd;
    pv = 1;
    case (m_st)
      1, 5: pd = $urandom_range(0, 1) ? TS1W : TS2W;
      2:    pd = TS2W;
      3:    pd = IDLEW;
      4:    pd = ($urandom_range(0, 49) == 0) ? TS1W : rnd_word();
      default: begin pd = rnd_word(); pv = 1'($urandom_range(0, 1)); end
    endcase
    if ($urandom_range(0, 99) < err) begin
      if ($urandom_range(0, 1) == 1) pv = 0;
      else pd = rnd_word();
    end
    rt = ($urandom_range(0, 99) < rt_pct);
    r  = (rt_pct > 0) && ($urandom_range(0, 499) == 0);
    step(r, 1'($urandom_range(0, 1)), rnd_word(), pv, pd, rt);
  endtask

  // reset then train with a perfect partner; returns edges until link up
  task automatic bring_up(output int cyc);
    step(1, 0, '0, 0, '0, 0);
    post();
    cyc = 0;
    for (int i = 1; i <= 200; i++) begin
      pstep(0, 0);
      post();
      if (link_up_o) begin
        cyc = i;
        break;
      end
    end
    chk("bring_up", W'(link_up_o), W'(1));
  endtask

  initial begin
    int cyc;

    // reset values
    step(1, 1, A5W, 1, TS1W, 1);
    post();
    chk("rst_state", W'(link_state_o), W'(0));
    chk("rst_up", W'(link_up_o), W'(0));
    chk("rst_ptxv", W'(phy_txvalid_o), W'(0));
    chk("rst_ptxd", phy_txdata_o, '0);
    chk("rst_drxv", W'(dll_rxvalid_o), W'(0));
    chk("rst_drxd", dll_rxdata_o, '0);

    // full training sequence timing
    bring_up(cyc);
    chk("linkup_cycles", W'(cyc), W'(52));

    // L0 datapath, one-cycle latency each way
    step(0, 1, A5W, 1, X5AW, 0);
    post();
    chk("l0_ptxd", phy_txdata_o, A5W);
    chk("l0_ptxv", W'(phy_txvalid_o), W'(1));
    chk("l0_drxd", dll_rxdata_o, X5AW);
    chk("l0_drxv", W'(dll_rxvalid_o), W'(1));
    step(0, 0, A5W, 0, X5AW, 0);
    post();
    chk("l0_ptxv_idle", W'(phy_txvalid_o), W'(0));
    chk("l0_drxv_idle", W'(dll_rxvalid_o), W'(0));

    // TS1 received in L0 -> recovery, then TS2 run -> config
    step(0, 0, '0, 1, TS1W, 0);
    post();
    chk("ts1_state", W'(link_state_o), W'(5));
    chk("ts1_up", W'(link_up_o), W'(0));
    chk("ts1_nofwd", W'(dll_rxvalid_o), W'(0));
    rx_word(TS2W, 7);
    post();
    chk("rec_7", W'(link_state_o), W'(5));
    rx_word(TS2W, 1);
    post();
    chk("rec_cfg", W'(link_state_o), W'(2));

    // retrain request drops the DLL word
    bring_up(cyc);
    step(0, 1, A5W, 0, '0, 1);
    post();
    chk("rt_state", W'(link_state_o), W'(5));
    chk("rt_drop", W'(phy_txvalid_o), W'(0));

    // reset together with retrain in L0
    bring_up(cyc);
    step(1, 1, A5W, 1, TS1W, 1);
    post();
    chk("rstrt_state", W'(link_state_o), W'(0));
    chk("rstrt_up", W'(link_up_o), W'(0));
    chk("rstrt_ptxv", W'(phy_txvalid_o), W'(0));

    // a gap restarts the TS1 run in POLL
    step(1, 0, '0, 0, '0, 0);
    silent(16);
    rx_word(TS1W, 10);
    silent(1);
    rx_word(TS1W, 7);
    post();
    chk("gap_poll", W'(link_state_o), W'(1));
    rx_word(TS1W, 1);
    post();
    chk("gap_cfg", W'(link_state_o), W'(2));

    // silent partner: timeout to DETECT, then back to POLL
    step(1, 0, '0, 0, '0, 0);
    silent(16);
    post();
    chk("to_poll", W'(link_state_o), W'(1));
    silent(1023);
    post();
    chk("to_1023", W'(link_state_o), W'(1));
    silent(1);
    post();
    chk("to_det", W'(link_state_o), W'(0));
    silent(16);
    post();
    chk("to_repoll", W'(link_state_o), W'(1));

    // timeout wins over a same-cycle advance
    step(1, 0, '0, 0, '0, 0);
    silent(16 + 1016);
    rx_word(TS1W, 7);
    post();
    chk("prio_pre", W'(link_state_o), W'(1));
    rx_word(TS1W, 1);
    post();
    chk("prio_det", W'(link_state_o), W'(0));

    // randomized partner traffic
    for (int rd = 0; rd < 6; rd++) begin
      step(1, 0, '0, 0, '0, 0);
      for (int i = 0; i < 400; i++)
        pstep((rd == 5) ? 100 : rd * 3, 3);
    end
    step(0, 0, '0, 0, '0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_link_ctrl.md
PIPE_LINK_CTRL -- requirements
Module: pipe_link_ctrl

Interface
REQ-001 SHALL have parameter PIPE_DATA_WIDTH, default 256, PIPE word width in bits (multiple of 32).
REQ-002 SHALL have parameter TS_RX_CNT, default 8, consecutive matching training words needed to advance.
REQ-003 SHALL have parameter TS_TX_MIN, default 16, minimum training words sent per training state before advancing.
REQ-004 SHALL have parameter IDLE_CNT, default 4, consecutive received IDLE words needed to enter L0.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024, cycles in a training state without advancing before fallback to DETECT.
REQ-006 SHALL have ports: one clock, reset synchronous and active-high:
- clk  in  1  sole clock.
- rst  in  1  synchronous active-high reset.
- dll_txdata_i  in  PIPE_DATA_WIDTH  TX word from DLL.
- dll_txvalid_i  in  1  TX word valid from DLL.
- dll_rxdata_o  out  PIPE_DATA_WIDTH  RX word to DLL.
- dll_rxvalid_o  out  1  RX word valid to DLL.
- phy_txdata_o  out  PIPE_DATA_WIDTH  word to PHY.
- phy_txvalid_o  out  1  PHY TX valid.
- phy_rxdata_i  in  PIPE_DATA_WIDTH  word from PHY.
- phy_rxvalid_i  in  1  PHY RX valid.
- retrain_i  in  1  single-cycle request to enter RECOVERY from L0.
- link_up_o  out  1  high only in L0.
- link_state_o  out  3  current FSM state encoding.

Function
REQ-007 SHALL define symbols TS1 = 32'h1E1E_4A4A, TS2 = 32'h2D2D_4545, IDLE = 32'h7C7C_0000, each replicated PIPE_DATA_WIDTH/32 times to form a word.
REQ-008 SHALL implement FSM states DETECT=0, POLL=1, CONFIG=2, IDLE_ST=3, L0=4, RECOVERY=5.
REQ-009 DETECT: phy_txvalid_o=0; after 16 cycles -> POLL.
REQ-010 POLL: send TS1 every cycle; -> CONFIG when rx match count >= TS_RX_CNT (TS1 or TS2 matches) and tx count >= TS_TX_MIN.
REQ-011 CONFIG: send TS2 every cycle; -> IDLE_ST when consecutive TS2 received >= TS_RX_CNT and tx count >= TS_TX_MIN.
REQ-012 IDLE_ST: send IDLE every cycle; -> L0 after IDLE_CNT consecutive IDLE words received.
REQ-013 L0: phy_tx = dll_tx registered, 1-cycle latency; dll_txvalid_i=0 gives phy_txvalid_o=0.
REQ-014 L0: dll_rx = phy_rx registered, 1-cycle latency, except a TS1 word is not forwarded and moves the FSM to RECOVERY.
REQ-015 L0: retrain_i=1 -> RECOVERY next cycle; any DLL word presented that cycle is dropped.
REQ-016 RECOVERY: send TS1; -> CONFIG on TS_RX_CNT consecutive TS1/TS2.
REQ-017 Match counter SHALL reset to 0 on phy_rxvalid_i=0 or a non-matching word, and saturate at TS_RX_CNT.
REQ-018 Tx and timeout counters SHALL clear on every state entry; tx counter saturates at TS_TX_MIN.
REQ-019 In POLL, CONFIG, IDLE_ST or RECOVERY, timeout counter reaching TIMEOUT_CYCLES SHALL force DETECT.
REQ-020 Timeout SHALL take priority over an advance in the same cycle.
REQ-021 dll_rxvalid_o SHALL be 0 outside L0.
REQ-022 link_up_o and link_state_o SHALL be registered and reflect the current state.

Reset
REQ-023 With rst=1 at a clk edge: state=DETECT, all counters 0, phy_txvalid_o=0, phy_txdata_o=0, dll_rxvalid_o=0, dll_rxdata_o=0, link_up_o=0, link_state_o=0.
REQ-024 Reset mid-L0 SHALL drop link_up_o on the next edge; in-flight words are discarded.

Structure
REQ-025 Package pipe_link_pkg SHALL hold the state enum and the TS1/TS2/IDLE 32-bit constants.
REQ-026 Sub-module pipe_sym_detect SHALL compare phy_rxdata_i against replicated TS1/TS2/IDLE and output per-symbol match flags.

Verification
REQ-027 Partner replies TS1 x8, TS2 x8, IDLE x4 -> link_up_o=1 at cycle 16+16+16+4+1 from reset release (approx., exact per FSM).
REQ-028 In L0, drive dll_txdata_i=0xA5.., valid=1 -> phy_txdata_o=0xA5.. one cycle later; phy rx 0x5A.. -> dll_rxdata_o one cycle later.
REQ-029 In POLL, 7 TS1, one gap (rxvalid=0), then 8 TS1 -> CONFIG only after the 8-word run.
REQ-030 Partner silent -> POLL for 1024 cycles, then DETECT, then POLL again after 16 cycles.
REQ-031 In L0, receive TS1 -> not forwarded, link_up_o=0 next cycle, state=RECOVERY; partner sends TS2 x8 -> CONFIG.
REQ-032 Pulse retrain_i in L0 together with rst=1 -> reset wins, state=DETECT.
